dense_layer_engine: RTL and testbench

Parametrised fully-connected layer engine that succeeds the fixed 8-node hidden layer and the 10-output layer.
- Computes OUT_DIM neurons over an IN_DIM input vector, using LANES parallel signed MACs per cycle.
- Each result is requantized by arithmetic shift with optional ReLU, then saturated back to DATA_W.
- Instances chain into multi-layer MLPs: done of layer k drives start of layer k+1, and argmax reads acc_vec of the last layer.

---
 rtl/mlp_pkg.sv | 46 ++++
 rtl/mac_lanes.sv | 43 ++++
 rtl/dense_layer_engine.sv | 132 +++++++++++++
 tb/tb_dense_layer_engine.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_pkg.sv
// Shared types, default layer parameters and the requantize/saturate helper
// used by every dense layer instance in the MLP.
package mlp_pkg;

  typedef enum logic [1:0] {IDLE, ACC, REQ} dle_state_t;

  localparam int DEF_IN_DIM    = 64;
  localparam int DEF_OUT_DIM   = 8;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_W_W       = 8;
  localparam int DEF_ACC_W     = 32;
  localparam int DEF_LANES     = 4;
  localparam int DEF_IN_SIGNED = 0;
  localparam int DEF_SHIFT     = 0;
  localparam int DEF_RELU_EN   = 1;

  // Accumulators up to SAT_W bits are sign-extended into this width before
  // requantization, so one function serves every ACC_W/DATA_W combination.
  localparam int SAT_W = 64;

  function automatic logic signed [SAT_W-1:0] requant_sat(
    input logic signed [SAT_W-1:0] acc,
    input int                      shift,
    input logic                    relu_en,
    input int                      data_w
  );
    logic signed [SAT_W-1:0] v;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    v = acc >>> shift;
    if (relu_en) begin
      lo = '0;
      hi = (SAT_W'(1) <<< data_w) - SAT_W'(1);
    end else begin
      hi = (SAT_W'(1) <<< (data_w - 1)) - SAT_W'(1);
      lo = -(SAT_W'(1) <<< (data_w - 1));
    end
    if (v < lo) begin
      return lo;
    end else if (v > hi) begin
      return hi;
    end
    return v;
  endfunction

endpackage

// File: rtl/mac_lanes.sv
// Combinational LANES-wide signed multiply with a balanced adder tree;
// returns the ACC_W-wide sum of x[l]*w[l].
module mac_lanes #(
  parameter int LANES     = 4,
  parameter int DATA_W    = 8,
  parameter int W_W       = 8,
  parameter int ACC_W     = 32,
  parameter int IN_SIGNED = 0
) (
  input  logic [LANES*DATA_W-1:0] x,
  input  logic [LANES*W_W-1:0]    w,
  output logic signed [ACC_W-1:0] sum
);

  localparam int P_W    = DATA_W + 1 + W_W;
  localparam int LEAVES = 1 << $clog2(LANES);

  // Heap-ordered tree: node[0] is the root, leaves start at LEAVES-1.
  logic signed [ACC_W-1:0] node [2*LEAVES-1];

  for (genvar g = 0; g < LEAVES; g++) begin : g_leaf
    if (g < LANES) begin : g_mul
      logic signed [DATA_W:0]  xe;
      logic signed [W_W-1:0]   we;
      logic signed [P_W-1:0]   prod;
      // One extra bit lets unsigned pixels and signed data share one multiplier.
      assign xe   = (IN_SIGNED != 0) ? {x[g*DATA_W+DATA_W-1], x[g*DATA_W +: DATA_W]}
                                     : {1'b0, x[g*DATA_W +: DATA_W]};
      assign we   = w[g*W_W +: W_W];
      assign prod = xe * we;
      assign node[LEAVES-1+g] = ACC_W'(prod);
    end else begin : g_pad
      assign node[LEAVES-1+g] = '0;
    end
  end

  for (genvar g = 0; g < LEAVES - 1; g++) begin : g_add
    assign node[g] = node[2*g+1] + node[2*g+2];
  end

  assign sum = node[0];

endmodule

// File: rtl/dense_layer_engine.sv
// Fully-connected layer: OUT_DIM neurons over an IN_DIM vector, LANES MACs per
// cycle, each result requantized (shift, optional ReLU, saturate) to DATA_W.
module dense_layer_engine
  import mlp_pkg::*;
#(
  parameter int IN_DIM    = DEF_IN_DIM,
  parameter int OUT_DIM   = DEF_OUT_DIM,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int W_W       = DEF_W_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int LANES     = DEF_LANES,
  parameter int IN_SIGNED = DEF_IN_SIGNED,
  parameter int SHIFT     = DEF_SHIFT,
  parameter int RELU_EN   = DEF_RELU_EN
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [IN_DIM*DATA_W-1:0]    in_vec,
  input  logic [OUT_DIM*IN_DIM*W_W-1:0] weight,
  input  logic [OUT_DIM*ACC_W-1:0]    bias,
  output logic [OUT_DIM*DATA_W-1:0]   out_vec,
  output logic [OUT_DIM*ACC_W-1:0]    acc_vec,
  output logic                        busy,
  output logic                        done
);

  localparam int BEATS = IN_DIM / LANES;
  localparam int O_W   = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam int B_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [O_W-1:0] O_LAST = O_W'(OUT_DIM - 1);
  localparam logic [B_W-1:0] B_LAST = B_W'(BEATS - 1);

  dle_state_t state;
  dle_state_t state_nx;

  logic [O_W-1:0]             o_cnt;
  logic [B_W-1:0]             beat_cnt;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    mac_sum;
  logic signed [ACC_W-1:0]    bias_sel;
  logic [IN_DIM*DATA_W-1:0]   x_reg;
  logic [LANES*DATA_W-1:0]    x_lanes;
  logic [LANES*W_W-1:0]       w_lanes;
  logic [DATA_W-1:0]          rq;
  int                         bias_idx;

  assign busy    = (state != IDLE);
  assign x_lanes = x_reg[int'(beat_cnt)*LANES*DATA_W +: LANES*DATA_W];
  assign w_lanes = weight[(int'(o_cnt)*IN_DIM + int'(beat_cnt)*LANES)*W_W +: LANES*W_W];
  assign rq      = DATA_W'(requant_sat(SAT_W'(acc), SHIFT, (RELU_EN != 0), DATA_W));

  // Bias preload: b[0] when a run starts, b[o+1] when moving to the next neuron.
  always_comb begin
    bias_idx = 0;
    if (state == REQ && o_cnt != O_LAST) begin
      bias_idx = int'(o_cnt) + 1;
    end
  end
  assign bias_sel = bias[bias_idx*ACC_W +: ACC_W];

  mac_lanes #(
    .LANES    (LANES),
    .DATA_W   (DATA_W),
    .W_W      (W_W),
    .ACC_W    (ACC_W),
    .IN_SIGNED(IN_SIGNED)
  ) u_mac (
    .x  (x_lanes),
    .w  (w_lanes),
    .sum(mac_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = ACC;
      ACC:     if (beat_cnt == B_LAST) state_nx = REQ;
      REQ:     state_nx = (o_cnt == O_LAST) ? IDLE : ACC;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_cnt    <= '0;
      beat_cnt <= '0;
      acc      <= '0;
      x_reg    <= '0;
      out_vec  <= '0;
      acc_vec  <= '0;
      done     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            x_reg    <= in_vec;
            o_cnt    <= '0;
            beat_cnt <= '0;
            acc      <= bias_sel;
          end
        end
        ACC: begin
          acc      <= acc + mac_sum;
          beat_cnt <= beat_cnt + B_W'(1);
        end
        REQ: begin
          acc_vec[int'(o_cnt)*ACC_W +: ACC_W]  <= acc;
          out_vec[int'(o_cnt)*DATA_W +: DATA_W] <= rq;
          if (o_cnt != O_LAST) begin
            o_cnt    <= o_cnt + O_W'(1);
            beat_cnt <= '0;
            acc      <= bias_sel;
          end else begin
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_layer_engine.sv
// Directed bench for dense_layer_engine: latency, saturation, signed/shift,
// start-while-busy, back-to-back, mid-run reset and a 200-vector random sweep.
module tb_dense_layer_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: IN_DIM=8, OUT_DIM=2, LANES=2, SHIFT=0, RELU_EN=1
  logic         start_a = 1'b0;
  logic [63:0]  in_vec_a = '0;
  logic [127:0] weight_a = '0;
  logic [63:0]  bias_a = '0;
  logic [15:0]  out_vec_a;
  logic [63:0]  acc_vec_a;
  logic         busy_a, done_a;

  // Instances B (RELU_EN=1) and C (RELU_EN=0) share stimulus
  logic         start_bc = 1'b0;
  logic [63:0]  in_vec_bc = '0;
  logic [63:0]  weight_bc = '0;
  logic [31:0]  bias_bc = '0;
  logic [7:0]   out_vec_b, out_vec_c;
  logic [31:0]  acc_vec_b, acc_vec_c;
  logic         busy_b, done_b, busy_c, done_c;

  // Instance D: IN_SIGNED=1, SHIFT=4, RELU_EN=0
  logic         start_d = 1'b0;
  logic [63:0]  in_vec_d = '0;
  logic [63:0]  weight_d = '0;
  logic [31:0]  bias_d = '0;
  logic [7:0]   out_vec_d;
  logic [31:0]  acc_vec_d;
  logic         busy_d, done_d;

  // Instance E: IN_DIM=64, OUT_DIM=10, LANES=8, SHIFT=6, RELU_EN=1
  logic          start_e = 1'b0;
  logic [511:0]  in_vec_e = '0;
  logic [5119:0] weight_e = '0;
  logic [319:0]  bias_e = '0;
  logic [79:0]   out_vec_e;
  logic [319:0]  acc_vec_e;
  logic          busy_e, done_e;

  logic [4:0] done_all;
  assign done_all = {done_e, done_d, done_c, done_b, done_a};

  dense_layer_engine #(.IN_DIM(8), .OUT_DIM(2), .DATA_W(8), .W_W(8), .ACC_W(32),
    .LANES(2), .IN_SIGNED(0), .SHIFT(0), .RELU_EN(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .in_vec(in_vec_a), .weight(weight_a),
    .bias(bias_a), .out_vec(out_vec_a), .acc_vec(acc_vec_a), .busy(busy_a), .done(done_a));

  dense_layer_engine #(.IN_DIM(8), .OUT_DIM(1), .DATA_W(8), .W_W(8), .ACC_W(32),
    .LANES(4), .IN_SIGNED(0), .SHIFT(0), .RELU_EN(1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_bc), .in_vec(in_vec_bc), .weight(weight_bc),
    .bias(bias_bc), .out_vec(out_vec_b), .acc_vec(acc_vec_b), .busy(busy_b), .done(done_b));

  dense_layer_engine #(.IN_DIM(8), .OUT_DIM(1), .DATA_W(8), .W_W(8), .ACC_W(32),
    .LANES(4), .IN_SIGNED(0), .SHIFT(0), .RELU_EN(0)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_bc), .in_vec(in_vec_bc), .weight(weight_bc),
    .bias(bias_bc), .out_vec(out_vec_c), .acc_vec(acc_vec_c), .busy(busy_c), .done(done_c));

  dense_layer_engine #(.IN_DIM(8), .OUT_DIM(1), .DATA_W(8), .W_W(8), .ACC_W(32),
    .LANES(4), .IN_SIGNED(1), .SHIFT(4), .RELU_EN(0)) u_d (
    .clk(clk), .rst_n(rst_n), .start(start_d), .in_vec(in_vec_d), .weight(weight_d),
    .bias(bias_d), .out_vec(out_vec_d), .acc_vec(acc_vec_d), .busy(busy_d), .done(done_d));

  dense_layer_engine #(.IN_DIM(64), .OUT_DIM(10), .DATA_W(8), .W_W(8), .ACC_W(32),
    .LANES(8), .IN_SIGNED(0), .SHIFT(6), .RELU_EN(1)) u_e (
    .clk(clk), .rst_n(rst_n), .start(start_e), .in_vec(in_vec_e), .weight(weight_e),
    .bias(bias_e), .out_vec(out_vec_e), .acc_vec(acc_vec_e), .busy(busy_e), .done(done_e));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Counts edges after the start edge until done is seen; -1 on timeout.
  task automatic wait_done(input int which, input int limit, output int cycles);
    cycles = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (done_all[which]) begin
        cycles = i;
        return;
      end
    end
  endtask

  function automatic longint ref_sat(input longint a, input int shift, input bit relu);
    longint v;
    v = a >>> shift;
    if (relu) begin
      if (v < 0) v = 0;
      if (v > 255) v = 255;
    end else begin
      if (v < -128) v = -128;
      if (v > 127) v = 127;
    end
    return v;
  endfunction

  int cyc;
  int busy_cnt;
  bit saw_done;
  int xr [64];
  int wr [10][64];
  int br [10];
  logic [319:0] exp_acc;
  logic [79:0]  exp_out;
  longint a;
  longint s;

  initial begin
    // ---------------- reset ----------------
    #3;
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_out", out_vec_a, 16'h0);
    check("rst_acc", acc_vec_a, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ---------------- basic latency (A) ----------------
    in_vec_a = {8{8'h01}};
    weight_a = {{8{8'hFF}}, {8{8'h02}}};
    bias_a   = {32'd0, 32'd3};
    start_a  = 1'b1;
    tick();
    start_a  = 1'b0;
    busy_cnt = busy_a ? 1 : 0;
    cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (busy_a) busy_cnt++;
      if (done_a) begin
        cyc = i;
        break;
      end
    end
    check("a_latency", cyc, 10);
    check("a_busy_cycles", busy_cnt, 10);
    check("a_acc", acc_vec_a, {32'hFFFF_FFF8, 32'd19});
    check("a_out", out_vec_a, {8'h00, 8'd19});
    tick();
    check("a_done_one_cycle", done_a, 1'b0);

    // ---------------- start while busy is ignored (A) ----------------
    in_vec_a = {8{8'h01}};
    start_a  = 1'b1;
    tick();
    start_a  = 1'b0;
    in_vec_a = {8{8'h02}};
    tick(); tick(); tick();
    start_a  = 1'b1;
    tick();
    start_a  = 1'b0;
    wait_done(0, 40, cyc);
    check("a_busy_start_done", (cyc > 0), 1'b1);
    check("a_busy_start_acc", acc_vec_a, {32'hFFFF_FFF8, 32'd19});
    check("a_busy_start_out", out_vec_a, {8'h00, 8'd19});

    // ---------------- back-to-back with start held (A) ----------------
    in_vec_a = {8{8'h01}};
    start_a  = 1'b1;
    tick();
    wait_done(0, 40, cyc);
    check("a_b2b_first", cyc, 10);
    wait_done(0, 40, cyc);
    start_a = 1'b0;
    check("a_b2b_gap", cyc, 11);
    check("a_b2b_acc", acc_vec_a, {32'hFFFF_FFF8, 32'd19});
    tick(); tick();
    check("a_b2b_no_third", busy_a, 1'b0);

    // ---------------- reset mid-run (A) ----------------
    in_vec_a = {8{8'h02}};
    start_a  = 1'b1;
    tick();
    start_a  = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("a_mid_out0", out_vec_a[7:0], 8'd35);
    rst_n = 1'b0;
    #1;
    check("a_rst_busy", busy_a, 1'b0);
    check("a_rst_done", done_a, 1'b0);
    check("a_rst_out", out_vec_a, 16'h0);
    check("a_rst_acc", acc_vec_a, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done_a) saw_done = 1'b1;
    end
    check("a_rst_no_done", saw_done, 1'b0);
    in_vec_a = {8{8'h01}};
    start_a  = 1'b1;
    tick();
    start_a  = 1'b0;
    wait_done(0, 40, cyc);
    check("a_fresh_latency", cyc, 10);
    check("a_fresh_acc", acc_vec_a, {32'hFFFF_FFF8, 32'd19});
    check("a_fresh_out", out_vec_a, {8'h00, 8'd19});

    // ---------------- saturation (B relu, C signed range) ----------------
    in_vec_bc = {8{8'hFF}};
    weight_bc = {8{8'h7F}};
    bias_bc   = 32'd0;
    start_bc  = 1'b1;
    tick();
    start_bc  = 1'b0;
    wait_done(1, 20, cyc);
    check("b_latency", cyc, 3);
    check("b_acc_pos", acc_vec_b, 32'd259080);
    check("b_out_pos", out_vec_b, 8'hFF);
    check("c_acc_pos", acc_vec_c, 32'd259080);
    check("c_out_pos", out_vec_c, 8'h7F);
    tick();
    weight_bc = {8{8'h80}};
    start_bc  = 1'b1;
    tick();
    start_bc  = 1'b0;
    wait_done(2, 20, cyc);
    check("c_latency", cyc, 3);
    check("b_acc_neg", acc_vec_b, 32'hFFFC_0400);
    check("b_out_neg", out_vec_b, 8'h00);
    check("c_out_neg", out_vec_c, 8'h80);

    // ---------------- signed inputs with shift (D) ----------------
    in_vec_d = {8{8'hFD}};
    weight_d = {8{8'h05}};
    bias_d   = 32'd0;
    start_d  = 1'b1;
    tick();
    start_d  = 1'b0;
    wait_done(3, 20, cyc);
    check("d_acc_m120", acc_vec_d, 32'hFFFF_FF88);
    check("d_out_m8", out_vec_d, 8'hF8);
    tick();
    in_vec_d = {8{8'h03}};
    bias_d   = 32'd7;
    start_d  = 1'b1;
    tick();
    start_d  = 1'b0;
    wait_done(3, 20, cyc);
    check("d_acc_127", acc_vec_d, 32'd127);
    check("d_out_7", out_vec_d, 8'h07);
    tick();
    in_vec_d = {8{8'h80}};
    weight_d = {8{8'h7F}};
    bias_d   = 32'd0;
    start_d  = 1'b1;
    tick();
    start_d  = 1'b0;
    wait_done(3, 20, cyc);
    check("d_acc_neg", acc_vec_d, 32'hFFFE_0400);
    check("d_out_sat", out_vec_d, 8'h80);

    // ---------------- random vectors (E) ----------------
    for (int n = 0; n < 200; n++) begin
      tick();
      for (int i = 0; i < 64; i++) begin
        xr[i] = int'($urandom_range(0, 255));
        in_vec_e[i*8 +: 8] = 8'(xr[i]);
      end
      for (int o = 0; o < 10; o++) begin
        br[o] = int'($urandom_range(0, 40000)) - 20000;
        bias_e[o*32 +: 32] = 32'(br[o]);
        for (int i = 0; i < 64; i++) begin
          wr[o][i] = int'($urandom_range(0, 255)) - 128;
          weight_e[(o*64+i)*8 +: 8] = 8'(wr[o][i]);
        end
      end
      for (int o = 0; o < 10; o++) begin
        a = longint'(br[o]);
        for (int i = 0; i < 64; i++) a += longint'(xr[i]) * longint'(wr[o][i]);
        exp_acc[o*32 +: 32] = 32'(a);
        s = ref_sat(a, 6, 1'b1);
        exp_out[o*8 +: 8] = 8'(s);
      end
      start_e = 1'b1;
      tick();
      start_e = 1'b0;
      in_vec_e = '0;
      wait_done(4, 200, cyc);
      check($sformatf("e_latency[%0d]", n), cyc, 90);
      check($sformatf("e_acc[%0d]", n), acc_vec_e, exp_acc);
      check($sformatf("e_out[%0d]", n), out_vec_e, exp_out);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
